// File: rtl/mvm_mac_sequencer_if.sv
// Handshake and address bus between the MVM control logic and the MAC sequencer.
// The master side drives start/hold; the slave (sequencer) drives everything else.
interface mvm_mac_sequencer_if #(
  parameter int AW_A = 4,
  parameter int AW_X = 2,
  parameter int AW_Y = 2
);
  logic            start;
  logic            hold;
  logic            busy;
  logic            done;
  logic [AW_A-1:0] addr_a;
  logic [AW_X-1:0] addr_x;
  logic            mac_valid;
  logic            mac_first;
  logic            wr_en_y;
  logic [AW_Y-1:0] addr_y;

  modport master (
    output start, hold,
    input  busy, done, addr_a, addr_x, mac_valid, mac_first, wr_en_y, addr_y
  );

  modport slave (
    input  start, hold,
    output busy, done, addr_a, addr_x, mac_valid, mac_first, wr_en_y, addr_y
  );
endinterface

// File: rtl/mvm_mac_sequencer.sv
// Address/control sequencer for the matrix-vector multiply datapath.
// Walks an MxN matrix row by row, issuing operand read addresses to a pipelined
// MAC, and carries row-completion tags through a LAT-deep delay line so that each
// result-memory write lines up with the accumulated MAC output.
module mvm_mac_sequencer #(
  parameter int M    = 3,
  parameter int N    = 3,
  parameter int LAT  = 3,
  parameter int AW_A = (M * N > 1) ? $clog2(M * N) : 1,
  parameter int AW_X = (N > 1) ? $clog2(N) : 1,
  parameter int AW_Y = (M > 1) ? $clog2(M) : 1
) (
  input  logic               clk,
  input  logic               reset,
  mvm_mac_sequencer_if.slave bus
);

  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_issue;
  logic            w_begin;
  logic            w_last;
  logic            w_col_end;

  logic [AW_Y-1:0] r_row;
  logic [AW_X-1:0] r_col;
  logic [AW_A-1:0] r_lin;      // row*N+col kept as a running count, no multiplier
  logic [LW-1:0]   r_dcnt;

  logic [LAT-1:0]  r_dl_v;
  logic [AW_Y-1:0] r_dl_row [LAT];

  logic            r_busy;
  logic            r_done;
  logic [AW_A-1:0] r_addr_a;
  logic [AW_X-1:0] r_addr_x;
  logic            r_mac_valid;
  logic            r_mac_first;
  logic            r_wr_en_y;
  logic [AW_Y-1:0] r_addr_y;

  assign w_col_end = (r_col == AW_X'(N - 1));
  assign w_last    = (r_lin == AW_A'(M * N - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE also accepts a start so back-to-back passes lose no cycle.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_begin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next  = S_ISSUE;
          w_begin = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.hold) begin
          w_issue = 1'b1;
          if (w_last) begin
            w_next = S_DRAIN;
          end else begin
            w_next = S_ISSUE;
          end
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == LW'(LAT - 1)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_next  = S_ISSUE;
          w_begin = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Row/column/linear counters and the drain-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_lin  <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_begin) begin
        r_row <= '0;
        r_col <= '0;
        r_lin <= '0;
      end else if (w_issue) begin
        r_lin <= r_lin + AW_A'(1);
        if (w_col_end) begin
          r_col <= '0;
          r_row <= r_row + AW_Y'(1);
        end else begin
          r_col <= r_col + AW_X'(1);
        end
      end
      if (r_state == S_DRAIN) begin
        r_dcnt <= r_dcnt + LW'(1);
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  // Row-completion delay line; shifts every cycle so hold never stalls queued writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dl_v <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_dl_row[i] <= '0;
      end
    end else begin
      r_dl_v[0]   <= w_issue & w_col_end;
      r_dl_row[0] <= r_row;
      for (int i = 1; i < LAT; i++) begin
        r_dl_v[i]   <= r_dl_v[i-1];
        r_dl_row[i] <= r_dl_row[i-1];
      end
    end
  end

  // Registered outputs; operand addresses keep their last value between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_addr_a    <= '0;
      r_addr_x    <= '0;
      r_mac_valid <= 1'b0;
      r_mac_first <= 1'b0;
      r_wr_en_y   <= 1'b0;
      r_addr_y    <= '0;
    end else begin
      r_busy      <= (r_state != S_IDLE);
      r_done      <= (r_state == S_DONE);
      r_mac_valid <= w_issue;
      r_mac_first <= w_issue & (r_col == AW_X'(0));
      if (w_issue) begin
        r_addr_a <= r_lin;
        r_addr_x <= r_col;
      end
      r_wr_en_y <= r_dl_v[LAT-1];
      if (r_dl_v[LAT-1]) begin
        r_addr_y <= r_dl_row[LAT-1];
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.addr_a    = r_addr_a;
  assign bus.addr_x    = r_addr_x;
  assign bus.mac_valid = r_mac_valid;
  assign bus.mac_first = r_mac_first;
  assign bus.wr_en_y   = r_wr_en_y;
  assign bus.addr_y    = r_addr_y;

endmodule
